calc_seq: RTL and testbench
===========================

Name: calc_seq

Overview:
- Programmable sequencer that drives the calc datapath (accumulator + ALU) in place of the board buttons and switches.
- Holds a small program of {op, operand} steps, loaded while idle.
- On start: clears the calc accumulator, applies each step in order with one accumulate strobe per step, and captures the accumulator after every step.
- Sits between the board/host control logic and the calc instance; its outputs connect to calc's btnu, btnl, btnc, btnr, btnd and sw inputs, and calc's led output feeds back into it.

Parameters:
- DEPTH, 8, number of program entries (power of 2, 2..16).
- AW, 3, program address width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active low.
- prog_we  in  1  program write strobe; honoured only in IDLE.
- prog_addr  in  AW  program write address.
- prog_op  in  3  opcode, mapped directly to {btnl, btnc, btnr}.
- prog_data  in  16  operand, driven onto sw.
- prog_len  in  AW+1  number of steps to run; sampled at start.
- start  in  1  begin a run; honoured only in IDLE.
- abort  in  1  cancel a run in progress.
- acc_in  in  16  calc led (accumulator) value.
- c_btnu  out  1  calc accumulator clear.
- c_btnl  out  1  calc op bit 2.
- c_btnc  out  1  calc op bit 1.
- c_btnr  out  1  calc op bit 0.
- c_btnd  out  1  calc accumulate strobe.
- c_sw  out  16  calc operand.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal run completion.
- step_idx  out  AW  index of the step currently being applied.
- result  out  16  accumulator value captured at the last CAPTURE.

Behaviour:
- Calc contract: calc clears its accumulator on the clk edge where btnu=1. It loads ALU(acc, sw, {btnl, btnc, btnr}) on the clk edge where btnd=1. Calc's led output equals the accumulator.
- Reset (rst_n=0 at a clk edge): state returns to IDLE. All outputs go to 0: result=0, step_idx=0, done=0, busy=0, all c_* outputs 0. Program memory contents are not reset.
- Reset mid-run behaves identically to reset from idle.
- Program store: DEPTH x 19-bit registers. Written on a clk edge when prog_we=1 and state is IDLE. Writes are ignored when not in IDLE.
- Run length: len = min(prog_len, DEPTH), latched on the edge where start is accepted.
- FSM states: IDLE, CLEAR, SETUP, STROBE, CAPTURE, FIN.
  - IDLE: all c_* outputs 0. If start=1, go to CLEAR and set step_idx=0.
  - CLEAR: c_btnu=1 for exactly one cycle. If len=0, go to FIN; otherwise go to SETUP.
  - SETUP: drive c_sw and op bits from entry[step_idx], with c_btnd=0. Go to STROBE.
  - STROBE: hold the same c_sw and op bits, with c_btnd=1 for exactly one cycle. Go to CAPTURE.
  - CAPTURE: hold c_sw and op bits, with c_btnd=0. On the exit edge, result<=acc_in. If step_idx==len-1, go to FIN; otherwise step_idx increments and the next state is SETUP.
  - FIN: done=1 for one cycle, c_* outputs 0. Go to IDLE.
- Timing: each step takes 3 cycles. With the start-accept edge as edge 0, done is high in cycle 3*len+2. For len=0, done is high in cycle 2.
- c_btnu and c_btnd are never high in the same cycle. c_btnd is high for exactly len cycles per run.
- start while busy: ignored.
- abort=1 in any non-IDLE state: next state is IDLE, c_* outputs go to 0, done is not pulsed, and result holds its last value. abort has priority over every other transition, including the FIN-to-IDLE transition.
- start and abort high together in IDLE: abort has no effect and start is accepted.
- step_idx stays at its last value after a run; it is reset to 0 at the next start.
- Opcode map ({btnl, btnc, btnr}): 010 ADD, 011 SUB, 001 OR, 000 AND, 111 XOR, 101 LSL, 110 SRA, 100 LT. calc_seq passes the opcode through without interpreting it.

Optional Feature:
- Macro: CALC_SEQ_ZERO_HALT_EN.
- When defined:
  - Adds output zero_halt (1 bit).
  - In CAPTURE, if acc_in==0 and step_idx<len-1, the sequencer goes to FIN early and sets zero_halt=1.
  - zero_halt stays high until the next accepted start or reset.
  - done still pulses in FIN.
- When undefined: no zero_halt port, and every run executes all len steps regardless of the accumulator value.

Test Plan:
- Load {ADD 0x354a, SUB 0x1234, OR 0x1001, AND 0xf0f0}, len=4, start -> c_btnu pulses once, c_btnd pulses 4 times, each pulse 3 cycles apart; result=0x3010; done is high in cycle 14.
- len=2 with the same program -> result=0x2316; done is high in cycle 8; step_idx=1 after the run.
- len=0, start -> one c_btnu pulse, no c_btnd pulse; done is high in cycle 2; result is unchanged.
- Assert abort during the second STROBE of a 4-step run -> IDLE on the next cycle, no done pulse, result=0x354a. Assert prog_we and start during the run -> the program is unchanged and the run is not restarted.
- Assert rst_n=0 during SETUP -> all outputs 0 on the next cycle. A following start with the programmed entries runs normally.
- With CALC_SEQ_ZERO_HALT_EN: program {ADD 0x0005, SUB 0x0005, ADD 0x0007}, len=3 -> run stops after step 1; zero_halt=1, result=0x0000, c_btnd pulsed 2 times.

Source files
------------

// File: rtl/calc_seq_if.sv
// Bus between calc_seq and the calc datapath: button/switch drive out, accumulator (led) back.
// master = sequencer side, slave = calc side.
interface calc_seq_if;
    logic        c_btnu;
    logic        c_btnl;
    logic        c_btnc;
    logic        c_btnr;
    logic        c_btnd;
    logic [15:0] c_sw;
    logic [15:0] acc_in;

    modport master (
        output c_btnu, c_btnl, c_btnc, c_btnr, c_btnd, c_sw,
        input  acc_in
    );

    modport slave (
        input  c_btnu, c_btnl, c_btnc, c_btnr, c_btnd, c_sw,
        output acc_in
    );
endinterface

// File: rtl/calc_seq.sv
// Programmable sequencer replacing the calc board buttons/switches with a stored {op, operand} program.
// Optional early stop on a zero accumulator: define CALC_SEQ_ZERO_HALT_EN (adds zero_halt output).
module calc_seq #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [2:0]    prog_op,
    input  logic [15:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          abort,
    calc_seq_if.master    cbus,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] step_idx,
    output logic [15:0]   result
`ifdef CALC_SEQ_ZERO_HALT_EN
    ,
    output logic          zero_halt
`endif
);

    typedef enum logic [2:0] {StIdle, StClear, StSetup, StStrobe, StCapture, StFin} state_e;

    localparam logic [AW:0]   DepthLen = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LenOne   = (AW + 1)'(1);
    localparam logic [AW-1:0] IdxOne   = AW'(1);

    state_e        state_q;
    logic [AW-1:0] step_q;
    logic [AW:0]   len_q;
    logic [15:0]   result_q;
    logic          done_q;
    logic          btnu_q;
    logic          btnd_q;
    logic [2:0]    op_q;
    logic [15:0]   sw_q;
`ifdef CALC_SEQ_ZERO_HALT_EN
    logic          zh_q;
`endif

    logic [18:0]   mem_q [DEPTH];
    logic [AW:0]   len_sel;
    logic [AW-1:0] rd_idx;
    logic [18:0]   entry;
    logic          last_step;
    logic          zero_hit;

    always_comb begin
        len_sel   = (prog_len > DepthLen) ? DepthLen : prog_len;
        // CAPTURE preloads the following step's entry for SETUP.
        rd_idx    = (state_q == StCapture) ? step_q + IdxOne : step_q;
        entry     = mem_q[rd_idx];
        last_step = ({1'b0, step_q} == len_q - LenOne);
`ifdef CALC_SEQ_ZERO_HALT_EN
        zero_hit  = (cbus.acc_in == 16'h0000);
`else
        zero_hit  = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (prog_we && state_q == StIdle) begin
            mem_q[prog_addr] <= {prog_op, prog_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            step_q   <= '0;
            len_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            btnu_q   <= 1'b0;
            btnd_q   <= 1'b0;
            op_q     <= '0;
            sw_q     <= '0;
`ifdef CALC_SEQ_ZERO_HALT_EN
            zh_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle && abort) begin
                state_q <= StIdle;
                btnu_q  <= 1'b0;
                btnd_q  <= 1'b0;
                op_q    <= '0;
                sw_q    <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q <= StClear;
                            step_q  <= '0;
                            len_q   <= len_sel;
                            btnu_q  <= 1'b1;
`ifdef CALC_SEQ_ZERO_HALT_EN
                            zh_q    <= 1'b0;
`endif
                        end
                    end
                    StClear: begin
                        btnu_q <= 1'b0;
                        if (len_q == '0) begin
                            state_q <= StFin;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StSetup;
                            op_q    <= entry[18:16];
                            sw_q    <= entry[15:0];
                        end
                    end
                    StSetup: begin
                        state_q <= StStrobe;
                        btnd_q  <= 1'b1;
                    end
                    StStrobe: begin
                        state_q <= StCapture;
                        btnd_q  <= 1'b0;
                    end
                    StCapture: begin
                        result_q <= cbus.acc_in;
                        if (last_step || zero_hit) begin
                            state_q <= StFin;
                            done_q  <= 1'b1;
                            op_q    <= '0;
                            sw_q    <= '0;
`ifdef CALC_SEQ_ZERO_HALT_EN
                            if (!last_step) zh_q <= 1'b1;
`endif
                        end else begin
                            state_q <= StSetup;
                            step_q  <= step_q + IdxOne;
                            op_q    <= entry[18:16];
                            sw_q    <= entry[15:0];
                        end
                    end
                    StFin: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign cbus.c_btnu = btnu_q;
    assign cbus.c_btnd = btnd_q;
    assign cbus.c_btnl = op_q[2];
    assign cbus.c_btnc = op_q[1];
    assign cbus.c_btnr = op_q[0];
    assign cbus.c_sw   = sw_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign step_idx    = step_q;
    assign result      = result_q;
`ifdef CALC_SEQ_ZERO_HALT_EN
    assign zero_halt   = zh_q;
`endif

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq driving a behavioural calc accumulator/ALU model.
module tb_calc_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [2:0]  prog_addr;
    logic [2:0]  prog_op;
    logic [15:0] prog_data;
    logic [3:0]  prog_len;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [2:0]  step_idx;
    logic [15:0] result;
`ifdef CALC_SEQ_ZERO_HALT_EN
    logic        zero_halt;
`endif
    logic [15:0] acc;

    int checks = 0;
    int errors = 0;
    int r_done_cyc, r_done_cnt, r_nd, r_nu, r_first_d, r_last_d, r_overlap, r_end;

    always #5 clk = ~clk;

    calc_seq_if cbus();

    calc_seq #(.DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_op   (prog_op),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .start     (start),
        .abort     (abort),
        .cbus      (cbus),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx),
        .result    (result)
`ifdef CALC_SEQ_ZERO_HALT_EN
        ,
        .zero_halt (zero_halt)
`endif
    );

    function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
        case (op)
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b001:  return a | b;
            3'b000:  return a & b;
            3'b111:  return a ^ b;
            3'b101:  return a << b[3:0];
            3'b110:  return 16'($signed(a) >>> b[3:0]);
            default: return {15'b0, $signed(a) < $signed(b)};
        endcase
    endfunction

    // Behavioural calc: clear on btnu, ALU update on btnd, led = accumulator.
    always @(posedge clk) begin
        if (cbus.c_btnu) acc <= 16'h0000;
        else if (cbus.c_btnd) acc <= alu(acc, cbus.c_sw, {cbus.c_btnl, cbus.c_btnc, cbus.c_btnr});
    end
    assign cbus.acc_in = acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [2:0] addr, input logic [2:0] op, input logic [15:0] data);
        prog_we = 1'b1; prog_addr = addr; prog_op = op; prog_data = data;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    // Start a run and observe it cycle by cycle; cycle 1 is the one after the start-accept edge.
    task automatic run(input logic [3:0] len, input int abort_at, input int poke_at,
                       input int rst_at);
        int c;
        r_done_cyc = -1; r_done_cnt = 0; r_nd = 0; r_nu = 0;
        r_first_d = -1; r_last_d = -1; r_overlap = 0;
        prog_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        while (busy && c <= 60) begin
            if (done) begin r_done_cnt++; r_done_cyc = c; end
            if (cbus.c_btnd) begin
                r_nd++;
                if (r_first_d < 0) r_first_d = c;
                r_last_d = c;
            end
            if (cbus.c_btnu) begin
                r_nu++;
                if (cbus.c_btnd) r_overlap++;
            end
            if (c == abort_at) abort = 1'b1;
            if (c == rst_at) rst_n = 1'b0;
            if (c == poke_at) begin
                prog_we = 1'b1; prog_addr = 3'd0; prog_op = 3'b111; prog_data = 16'hdead;
                start = 1'b1;
            end
            @(posedge clk); #1;
            abort = 1'b0; prog_we = 1'b0; start = 1'b0; rst_n = 1'b1;
            c++;
        end
        r_end = c;
    endtask

    initial begin
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_op = '0; prog_data = '0;
        prog_len = '0; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_done", {30'b0, busy, done}, 32'h0);
        chk("rst_step_result", {13'b0, step_idx, result}, 32'h0);
        chk("rst_cbus", {11'b0, cbus.c_btnu, cbus.c_btnl, cbus.c_btnc, cbus.c_btnr,
                         cbus.c_btnd, cbus.c_sw}, 32'h0);
`ifdef CALC_SEQ_ZERO_HALT_EN
        chk("rst_zero_halt", {31'b0, zero_halt}, 32'h0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        load(3'd0, 3'b010, 16'h354a);
        load(3'd1, 3'b011, 16'h1234);
        load(3'd2, 3'b001, 16'h1001);
        load(3'd3, 3'b000, 16'hf0f0);
        for (int i = 4; i < 8; i++) load(3'(i), 3'b010, 16'h0001);

        // Four-step run
        run(4'd4, -1, -1, -1);
        chk("len4_done_cyc", r_done_cyc, 14);
        chk("len4_done_cnt", r_done_cnt, 1);
        chk("len4_btnu_cnt", r_nu, 1);
        chk("len4_btnd_cnt", r_nd, 4);
        chk("len4_first_strobe", r_first_d, 3);
        chk("len4_last_strobe", r_last_d, 12);
        chk("len4_overlap", r_overlap, 0);
        chk("len4_result", {16'b0, result}, 32'h3010);
        chk("len4_step_idx", {29'b0, step_idx}, 3);

        // Two-step run
        run(4'd2, -1, -1, -1);
        chk("len2_done_cyc", r_done_cyc, 8);
        chk("len2_btnd_cnt", r_nd, 2);
        chk("len2_result", {16'b0, result}, 32'h2316);
        chk("len2_step_idx", {29'b0, step_idx}, 1);

        // Zero-length run
        run(4'd0, -1, -1, -1);
        chk("len0_done_cyc", r_done_cyc, 2);
        chk("len0_btnu_cnt", r_nu, 1);
        chk("len0_btnd_cnt", r_nd, 0);
        chk("len0_result", {16'b0, result}, 32'h2316);

        // Length above DEPTH clamps to 8 steps
        run(4'd9, -1, -1, -1);
        chk("len9_done_cyc", r_done_cyc, 26);
        chk("len9_btnd_cnt", r_nd, 8);
        chk("len9_result", {16'b0, result}, 32'h3014);

        // Abort in the second STROBE, with write + start attempted in CAPTURE
        run(4'd4, 6, 4, -1);
        chk("abort_end_cyc", r_end, 7);
        chk("abort_done_cnt", r_done_cnt, 0);
        chk("abort_btnu_cnt", r_nu, 1);
        chk("abort_btnd_cnt", r_nd, 2);
        chk("abort_result", {16'b0, result}, 32'h354a);
        chk("abort_cbus", {11'b0, cbus.c_btnu, cbus.c_btnl, cbus.c_btnc, cbus.c_btnr,
                           cbus.c_btnd, cbus.c_sw}, 32'h0);

        // Program must be untouched by the write attempted during the run
        run(4'd4, -1, -1, -1);
        chk("prog_kept_result", {16'b0, result}, 32'h3010);
        chk("prog_kept_done_cyc", r_done_cyc, 14);

        // Reset during SETUP
        run(4'd4, -1, -1, 2);
        chk("midrst_end_cyc", r_end, 3);
        chk("midrst_busy_done", {30'b0, busy, done}, 32'h0);
        chk("midrst_step_result", {13'b0, step_idx, result}, 32'h0);
        chk("midrst_cbus", {11'b0, cbus.c_btnu, cbus.c_btnl, cbus.c_btnc, cbus.c_btnr,
                            cbus.c_btnd, cbus.c_sw}, 32'h0);

        run(4'd4, -1, -1, -1);
        chk("post_rst_result", {16'b0, result}, 32'h3010);
        chk("post_rst_done_cyc", r_done_cyc, 14);

`ifdef CALC_SEQ_ZERO_HALT_EN
        load(3'd0, 3'b010, 16'h0005);
        load(3'd1, 3'b011, 16'h0005);
        load(3'd2, 3'b010, 16'h0007);
        run(4'd3, -1, -1, -1);
        chk("zh_flag", {31'b0, zero_halt}, 1);
        chk("zh_result", {16'b0, result}, 32'h0000);
        chk("zh_btnd_cnt", r_nd, 2);
        chk("zh_done_cnt", r_done_cnt, 1);
        chk("zh_done_cyc", r_done_cyc, 8);
        run(4'd1, -1, -1, -1);
        chk("zh_cleared", {31'b0, zero_halt}, 0);
        chk("zh_len1_result", {16'b0, result}, 32'h0005);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
